// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle MIPS-subset controller.
// Build option MAIN_CTL_ADDI_EN adds the ADDIEX/ADDIWB states for ADDI.
package cpu_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      JUMP    = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
   } ctrl_t;

endpackage

// File: rtl/main_ctl_decode.sv
// Pure state -> control-vector decode (Moore part of the controller).
// ADDI states are decoded only when MAIN_CTL_ADDI_EN is defined.
module main_ctl_decode
   import cpu_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            // pc_write/ir_write are qualified with mem_ready by the parent
            ctrl.pc_write  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_src    = PCSRC_ALU;
         end
         DECODE: begin
            ctrl.alu_src_b = SRCB_IMMSH;
            ctrl.alu_op    = ALUOP_ADD;
         end
         MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         MEMRD: ctrl.iord = 1'b1;
         MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.branch    = 1'b1;
         end
         JUMP: begin
            ctrl.pc_src   = PCSRC_JUMP;
            ctrl.pc_write = 1'b1;
         end
`ifdef MAIN_CTL_ADDI_EN
         ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ADDIWB: ctrl.reg_write = 1'b1;
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main controller: state register, opcode-driven sequencing,
// mem_ready stalls and reset forcing. MAIN_CTL_ADDI_EN enables ADDI.
module main_control_fsm
   import cpu_pkg::*;
#(
   parameter int OPW  = 6,
   parameter int AOPW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OPW-1:0]  opcode,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            branch,
   output logic            iord,
   output logic            mem_write,
   output logic            ir_write,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [AOPW-1:0] alu_op,
   output logic [1:0]      pc_src,
   output logic            illegal_op,
   output logic [3:0]      state_dbg
);

   state_t state, next_state, dec_state;
   ctrl_t  ctrl;
   logic   bad_op;

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= next_state;
   end

   always_comb begin
      next_state = FETCH;
      bad_op     = 1'b0;
      case (state)
         FETCH:  next_state = mem_ready ? DECODE : FETCH;
         DECODE: begin
            if (opcode == OP_LW || opcode == OP_SW) next_state = MEMADR;
            else if (opcode == OP_RTYPE)            next_state = EXECUTE;
            else if (opcode == OP_BEQ)              next_state = BRANCH;
            else if (opcode == OP_J)                next_state = JUMP;
`ifdef MAIN_CTL_ADDI_EN
            else if (opcode == OP_ADDI)             next_state = ADDIEX;
`endif
            else                                    bad_op     = 1'b1;
         end
         // IR is frozen past FETCH, so opcode is still LW or SW here
         MEMADR:  next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
         MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
         EXECUTE: next_state = ALUWB;
`ifdef MAIN_CTL_ADDI_EN
         ADDIEX:  next_state = ADDIWB;
`endif
         default: next_state = FETCH;
      endcase
   end

   // In reset the selects follow FETCH while every enable is held low
   assign dec_state = rst ? FETCH : state;

   main_ctl_decode u_decode (
      .state (dec_state),
      .ctrl  (ctrl)
   );

   always_comb begin
      pc_write   = ctrl.pc_write  & ~rst & ((state != FETCH) | mem_ready);
      ir_write   = ctrl.ir_write  & ~rst & ((state != FETCH) | mem_ready);
      branch     = ctrl.branch    & ~rst;
      mem_write  = ctrl.mem_write & ~rst;
      reg_write  = ctrl.reg_write & ~rst;
      illegal_op = bad_op         & ~rst;
      iord       = ctrl.iord;
      reg_dst    = ctrl.reg_dst;
      mem_to_reg = ctrl.mem_to_reg;
      alu_src_a  = ctrl.alu_src_a;
      alu_src_b  = ctrl.alu_src_b;
      alu_op     = ctrl.alu_op;
      pc_src     = ctrl.pc_src;
      state_dbg  = state;
   end

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: table of per-cycle vectors fed
// through an expectation queue, plus hand-written multi-cycle checks.
module tb_main_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, branch, iord, mem_write, ir_write, reg_dst;
   logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state_dbg;

   main_control_fsm dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .branch(branch), .iord(iord), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // ctl bits: pw br iord mw irw rd m2r rw sa sb[1:0] aop[1:0] pcs[1:0] ill
   localparam logic [15:0] C_FETCH   = 16'h8820;
   localparam logic [15:0] C_FSTALL  = 16'h0020;
   localparam logic [15:0] C_DECODE  = 16'h0060;
   localparam logic [15:0] C_ILLEGAL = 16'h0061;
   localparam logic [15:0] C_MEMADR  = 16'h00C0;
   localparam logic [15:0] C_MEMRD   = 16'h2000;
   localparam logic [15:0] C_MEMWB   = 16'h0300;
   localparam logic [15:0] C_MEMWR   = 16'h3000;
   localparam logic [15:0] C_EXEC    = 16'h0090;
   localparam logic [15:0] C_ALUWB   = 16'h0500;
   localparam logic [15:0] C_BRANCH  = 16'h408A;
   localparam logic [15:0] C_JUMP    = 16'h8004;
   localparam logic [15:0] C_ADDIWB  = 16'h0100;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
   localparam logic [5:0] BAD = 6'b111111;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       mr;
      logic [3:0] st;
      logic [15:0] ctl;
   } vec_t;

   typedef struct {
      int          idx;
      logic [3:0]  st;
      logic [15:0] ctl;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   function automatic void add(logic r, logic [5:0] op, logic mr,
                               logic [3:0] st, logic [15:0] ctl);
      vec_t v;
      v.rst = r; v.op = op; v.mr = mr; v.st = st; v.ctl = ctl;
      tbl.push_back(v);
   endfunction

   function automatic logic [15:0] ctl_now();
      return {pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
              reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
   endfunction

   task automatic check(string name, logic [15:0] act, logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      int   ill_cnt, rw_cnt;

      // reset held, then LW with zero-wait memory
      add(1, LW, 1, 0, C_FSTALL);
      add(1, LW, 1, 0, C_FSTALL);
      add(0, LW, 1, 0, C_FETCH);
      add(0, LW, 1, 1, C_DECODE);
      add(0, LW, 1, 2, C_MEMADR);
      add(0, LW, 1, 3, C_MEMRD);
      add(0, LW, 1, 4, C_MEMWB);
      // SW with three wait cycles in MEMWR
      add(0, SW, 1, 0, C_FETCH);
      add(0, SW, 1, 1, C_DECODE);
      add(0, SW, 1, 2, C_MEMADR);
      add(0, SW, 0, 5, C_MEMWR);
      add(0, SW, 0, 5, C_MEMWR);
      add(0, SW, 0, 5, C_MEMWR);
      add(0, SW, 1, 5, C_MEMWR);
      // RTYPE then BEQ
      add(0, RT, 1, 0, C_FETCH);
      add(0, RT, 1, 1, C_DECODE);
      add(0, RT, 1, 6, C_EXEC);
      add(0, RT, 1, 7, C_ALUWB);
      add(0, BEQ, 1, 0, C_FETCH);
      add(0, BEQ, 1, 1, C_DECODE);
      add(0, BEQ, 1, 8, C_BRANCH);
      // J with one fetch stall
      add(0, JMP, 0, 0, C_FSTALL);
      add(0, JMP, 1, 0, C_FETCH);
      add(0, JMP, 1, 1, C_DECODE);
      add(0, JMP, 1, 9, C_JUMP);
      // undefined opcode
      add(0, BAD, 1, 0, C_FETCH);
      add(0, BAD, 1, 1, C_ILLEGAL);
      // ADDI: legal only with the option built in
      add(0, ADDI, 1, 0, C_FETCH);
`ifdef MAIN_CTL_ADDI_EN
      add(0, ADDI, 1, 1, C_DECODE);
      add(0, ADDI, 1, 10, C_MEMADR);
      add(0, ADDI, 1, 11, C_ADDIWB);
`else
      add(0, ADDI, 1, 1, C_ILLEGAL);
`endif
      // LW with a read stall
      add(0, LW, 1, 0, C_FETCH);
      add(0, LW, 1, 1, C_DECODE);
      add(0, LW, 1, 2, C_MEMADR);
      add(0, LW, 0, 3, C_MEMRD);
      add(0, LW, 1, 3, C_MEMRD);
      add(0, LW, 1, 4, C_MEMWB);
      // reset mid-store while memory is stalled
      add(0, SW, 1, 0, C_FETCH);
      add(0, SW, 1, 1, C_DECODE);
      add(0, SW, 1, 2, C_MEMADR);
      add(0, SW, 0, 5, C_MEMWR);
      add(1, SW, 0, 5, C_FSTALL);
      add(0, SW, 0, 0, C_FSTALL);
      add(0, SW, 0, 0, C_FSTALL);

      rst = 1'b1; opcode = LW; mem_ready = 1'b1;
      repeat (2) @(posedge clk);

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         rst = tbl[i].rst; opcode = tbl[i].op; mem_ready = tbl[i].mr;
         e.idx = i; e.st = tbl[i].st; e.ctl = tbl[i].ctl;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         check($sformatf("vec%0d state", e.idx), {12'd0, state_dbg}, {12'd0, e.st});
         check($sformatf("vec%0d ctl", e.idx), ctl_now(), e.ctl);
      end

      // after the abandoned store: no write enable for 8 cycles while stalled
      rw_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         rst = 1'b0; mem_ready = 1'b0;
         @(negedge clk);
         if (reg_write || mem_write || pc_write || ir_write || branch) rw_cnt++;
      end
      check("post_reset_writes", 16'(rw_cnt), 16'd0);

      // illegal opcode pulses exactly once, then J proceeds normally
      ill_cnt = 0;
      @(posedge clk); #1; opcode = BAD; mem_ready = 1'b1;
      @(negedge clk); if (illegal_op) ill_cnt++;
      @(posedge clk); #1;
      @(negedge clk); if (illegal_op) ill_cnt++;
      @(posedge clk); #1; opcode = JMP;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); if (illegal_op) ill_cnt++;
         @(posedge clk); #1;
      end
      check("illegal_pulse_count", 16'(ill_cnt), 16'd1);

      check("scoreboard_empty", 16'(sb.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
